// File: rtl/weight2_update_pkg.sv
// Shared layer-2 network package: default sizes and FSM state encoding
// for the layer-2 training blocks.
package weight2_update_pkg;

    localparam int W2_NWBITS     = 16;
    localparam int W2_NHIDDEN    = 256;
    localparam int W2_COUNT_BIT2 = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        UPDATE = 1'b1
    } w2_state_e;

    // True when every address representable in cb bits is a valid index,
    // so no range check is needed on the ports.
    function automatic bit w2_addr_full(input int nh, input int cb);
        return nh >= (1 << cb);
    endfunction

endpackage

// File: rtl/sat_add_w.sv
// Signed adder for weight/bias updates. The sum is formed one bit wider
// than the operands; WEIGHT2_UPDATE_SAT_EN selects clamping to the signed
// range, otherwise the low W bits are kept (two's-complement wrap).
module sat_add_w
    import weight2_update_pkg::*;
#(
    parameter int W = W2_NWBITS
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic signed [W-1:0] y_o
);

    logic signed [W:0] sum_w;

    assign sum_w = {a_i[W-1], a_i} + {b_i[W-1], b_i};

`ifdef WEIGHT2_UPDATE_SAT_EN
    // Clamp when the two top bits of the wide sum disagree (overflow).
    always_comb begin
        y_o = sum_w[W-1:0];
        if (sum_w[W] != sum_w[W-1]) begin
            y_o = sum_w[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end
`else
    assign y_o = sum_w[W-1:0];
`endif

endmodule

// File: rtl/weight2_update.sv
// Layer-2 weight/bias update engine. A start pulse launches a stream of
// NHIDDEN per-index deltas that are accumulated into the weight store, with
// a single bias delta applied on the first stream cycle. A load port fills
// the store while idle and a registered read port serves inference.
// Optional build macro: WEIGHT2_UPDATE_SAT_EN (saturating sums).
module weight2_update
    import weight2_update_pkg::*;
#(
    parameter int NWBITS     = W2_NWBITS,
    parameter int NHIDDEN    = W2_NHIDDEN,
    parameter int COUNT_BIT2 = W2_COUNT_BIT2
) (
    input  logic                         clk,
    input  logic                         reset_b,
    input  logic                         start_pos,
    input  logic                         start_neg,
    input  logic signed [NWBITS-1:0]     delta_weight,
    input  logic signed [NWBITS-1:0]     delta_bias,
    input  logic                         wr_en,
    input  logic        [COUNT_BIT2-1:0] wr_addr,
    input  logic signed [NWBITS-1:0]     wr_data,
    input  logic                         rd_en,
    input  logic        [COUNT_BIT2-1:0] rd_addr,
    output logic signed [NWBITS-1:0]     rd_data,
    output logic signed [NWBITS-1:0]     bias,
    output logic                         busy,
    output logic                         done
);

    localparam logic [COUNT_BIT2-1:0] LAST_IDX = COUNT_BIT2'(NHIDDEN - 1);

    w2_state_e                   state_q, state_d;
    logic     [COUNT_BIT2-1:0]   cnt_q, cnt_d;
    logic                        done_q, done_d;
    logic                        upd_we;
    logic                        bias_we;
    logic                        load_we;
    logic                        rd_ok;
    logic                        wr_ok;
    logic signed [NWBITS-1:0]    weight_q [NHIDDEN];
    logic signed [NWBITS-1:0]    bias_q;
    logic signed [NWBITS-1:0]    rd_data_q;
    logic signed [NWBITS-1:0]    wsum;
    logic signed [NWBITS-1:0]    bsum;

    // Address range checks collapse to constants when the index width
    // exactly covers the store.
    generate
        if (w2_addr_full(NHIDDEN, COUNT_BIT2)) begin : g_addr_full
            assign rd_ok = 1'b1;
            assign wr_ok = 1'b1;
        end else begin : g_addr_part
            assign rd_ok = (rd_addr < COUNT_BIT2'(NHIDDEN));
            assign wr_ok = (wr_addr < COUNT_BIT2'(NHIDDEN));
        end
    endgenerate

    sat_add_w #(.W(NWBITS)) u_add_weight (
        .a_i (weight_q[cnt_q]),
        .b_i (delta_weight),
        .y_o (wsum)
    );

    sat_add_w #(.W(NWBITS)) u_add_bias (
        .a_i (bias_q),
        .b_i (delta_bias),
        .y_o (bsum)
    );

    // Load port is only honoured while no stream is running.
    assign load_we = wr_en && wr_ok && (state_q == IDLE);

    // State register, stream index counter and done pulse.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; both start pulses launch the same stream, since the
    // delta sign travels with the data. Starts are ignored mid-stream.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        upd_we  = 1'b0;
        bias_we = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_pos || start_neg) begin
                    state_d = UPDATE;
                    cnt_d   = '0;
                end
            end
            UPDATE: begin
                upd_we  = 1'b1;
                bias_we = (cnt_q == '0);
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Weight store: stream accumulation has priority (the load port is
    // blocked while streaming anyway); cleared entirely on reset.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < NHIDDEN; i++) begin
                weight_q[i] <= '0;
            end
        end else if (upd_we) begin
            weight_q[cnt_q] <= wsum;
        end else if (load_we) begin
            weight_q[wr_addr] <= wr_data;
        end
    end

    // Bias accumulates once per stream, on its first cycle.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            bias_q <= '0;
        end else if (bias_we) begin
            bias_q <= bsum;
        end
    end

    // Registered read; sees the pre-update value on a same-cycle collision
    // and holds for idle or out-of-range requests.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            rd_data_q <= '0;
        end else if (rd_en && rd_ok) begin
            rd_data_q <= weight_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;
    assign bias    = bias_q;
    assign busy    = (state_q == UPDATE);
    assign done    = done_q;

endmodule
